// File: rtl/window_3x3_assembler.sv
// Assembles non-overlapping 3x3 windows from three row FIFOs (3 pixels per row each)
// and presents them on a valid/ready output with column/row indices.
module window_3x3_assembler #(
    parameter int WIN_PER_ROW  = 10,
    parameter int NUM_WIN_ROWS = 10,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      row0_data,
    input  logic [23:0]      row1_data,
    input  logic [23:0]      row2_data,
    input  logic [3:0]       row0_count,
    input  logic [3:0]       row1_count,
    input  logic [3:0]       row2_count,
    output logic             pop,
    output logic [71:0]      window_data,
    output logic             window_valid,
    input  logic             window_ready,
    output logic [CNT_W-1:0] win_col,
    output logic [CNT_W-1:0] win_row,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIN_PER_ROW - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(NUM_WIN_ROWS - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] col_cnt_reg, row_cnt_reg;
    logic             all_issued_reg;
    logic [71:0]      window_data_reg;
    logic             window_valid_reg;
    logic [CNT_W-1:0] win_col_reg, win_row_reg;

    logic [3:0] row_count_arr [3];
    logic [2:0] row_ok;
    logic       fire;
    logic       transfer;

    assign row_count_arr[0] = row0_count;
    assign row_count_arr[1] = row1_count;
    assign row_count_arr[2] = row2_count;

    // A full 3-pixel group must be present on every row before a window can be formed.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row_ok
            assign row_ok[gi] = (row_count_arr[gi] >= 4'd3);
        end
    endgenerate

    assign transfer = window_valid_reg & window_ready;

    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                fire = (&row_ok) & (~window_valid_reg | window_ready) & ~all_issued_reg;
                if (all_issued_reg && transfer) state_next = DONE_S;
            end
            DONE_S: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            col_cnt_reg    <= '0;
            row_cnt_reg    <= '0;
            all_issued_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                col_cnt_reg    <= '0;
                row_cnt_reg    <= '0;
                all_issued_reg <= 1'b0;
            end else if (fire) begin
                if (col_cnt_reg == COL_LAST) begin
                    col_cnt_reg <= '0;
                    row_cnt_reg <= row_cnt_reg + 1'b1;
                    if (row_cnt_reg == ROW_LAST) all_issued_reg <= 1'b1;
                end else begin
                    col_cnt_reg <= col_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Output register: a fire always reloads (covers back-to-back), a bare transfer empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_data_reg  <= '0;
            window_valid_reg <= 1'b0;
            win_col_reg      <= '0;
            win_row_reg      <= '0;
        end else if (fire) begin
            window_data_reg  <= {row2_data, row1_data, row0_data};
            window_valid_reg <= 1'b1;
            win_col_reg      <= col_cnt_reg;
            win_row_reg      <= row_cnt_reg;
        end else if (transfer) begin
            window_valid_reg <= 1'b0;
        end
    end

    assign pop          = fire;
    assign window_data  = window_data_reg;
    assign window_valid = window_valid_reg;
    assign win_col      = win_col_reg;
    assign win_row      = win_row_reg;
    assign busy         = (state_reg == RUN);
    assign done         = (state_reg == DONE_S);

endmodule

// File: tb/tb_window_3x3_assembler.sv
// Self-checking bench: a 2x2 instance for directed frames and a 10x10 instance for
// randomized frames, both watched by a queue-based scoreboard of expected windows.
module tb_window_3x3_assembler;

    localparam int W_A = 2, R_A = 2, W_B = 10, R_B = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b, ready_a, ready_b;
    logic [23:0] d0, d1, d2;
    logic [3:0]  c0, c1, c2;

    logic        pop_a, valid_a, busy_a, done_a;
    logic [71:0] data_a;
    logic [7:0]  col_a, row_a;
    logic        pop_b, valid_b, busy_b, done_b;
    logic [71:0] data_b;
    logic [7:0]  col_b, row_b;

    window_3x3_assembler #(.WIN_PER_ROW(W_A), .NUM_WIN_ROWS(R_A), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .row0_data(d0), .row1_data(d1), .row2_data(d2),
        .row0_count(c0), .row1_count(c1), .row2_count(c2),
        .pop(pop_a), .window_data(data_a), .window_valid(valid_a), .window_ready(ready_a),
        .win_col(col_a), .win_row(row_a), .busy(busy_a), .done(done_a)
    );

    window_3x3_assembler #(.WIN_PER_ROW(W_B), .NUM_WIN_ROWS(R_B), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .row0_data(d0), .row1_data(d1), .row2_data(d2),
        .row0_count(c0), .row1_count(c1), .row2_count(c2),
        .pop(pop_b), .window_data(data_b), .window_valid(valid_b), .window_ready(ready_b),
        .win_col(col_b), .win_row(row_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: windows are issued in raster order; each pop captures the presented rows.
    typedef struct {
        logic [71:0] data;
        int          col;
        int          row;
    } win_t;

    win_t exp_q[$];
    int   m_issued = 0, m_accepted = 0;
    bit   m_running = 0, m_done_now = 0;

    always @(negedge clk) begin
        logic        pop_m, valid_m, busy_m, done_m, start_m, ready_m;
        logic [71:0] data_m;
        logic [7:0]  col_m, row_m;
        int          w_m, total_m;
        bit          exp_pop, idle_now, nd;
        pop_m   = sel ? pop_b   : pop_a;
        valid_m = sel ? valid_b : valid_a;
        busy_m  = sel ? busy_b  : busy_a;
        done_m  = sel ? done_b  : done_a;
        start_m = sel ? start_b : start_a;
        ready_m = sel ? ready_b : ready_a;
        data_m  = sel ? data_b  : data_a;
        col_m   = sel ? col_b   : col_a;
        row_m   = sel ? row_b   : row_a;
        w_m     = sel ? W_B : W_A;
        total_m = sel ? W_B * R_B : W_A * R_A;
        if (reset) begin
            exp_q.delete();
            m_issued = 0; m_accepted = 0; m_running = 0; m_done_now = 0;
            chk("rst_pop", pop_m, 0);
            chk("rst_valid", valid_m, 0);
            chk("rst_busy", busy_m, 0);
            chk("rst_done", done_m, 0);
            chk("rst_data", data_m, 0);
        end else begin
            exp_pop = m_running && c0 >= 3 && c1 >= 3 && c2 >= 3 &&
                      (exp_q.size() == 0 || ready_m) && m_issued < total_m;
            chk("mon_pop", pop_m, exp_pop);
            chk("mon_valid", valid_m, exp_q.size() > 0);
            chk("mon_busy", busy_m, m_running);
            chk("mon_done", done_m, m_done_now);
            if (exp_q.size() > 0) begin
                chk("mon_data", data_m, exp_q[0].data);
                chk("mon_col", col_m, exp_q[0].col);
                chk("mon_row", row_m, exp_q[0].row);
            end
            idle_now = !m_running && !m_done_now;
            nd = 0;
            if (exp_q.size() > 0 && ready_m) begin
                $display("window col=%0d row=%0d data=%h", exp_q[0].col, exp_q[0].row, exp_q[0].data);
                void'(exp_q.pop_front());
                m_accepted++;
                if (m_accepted == total_m) begin
                    nd = 1;
                    m_running = 0;
                end
            end
            if (exp_pop) begin
                exp_q.push_back('{{d2, d1, d0}, m_issued % w_m, m_issued / w_m});
                m_issued++;
            end
            if (idle_now && start_m) begin
                m_running = 1; m_issued = 0; m_accepted = 0;
            end
            m_done_now = nd;
        end
    end

    typedef struct {
        logic [23:0] r0, r1, r2;
        logic [71:0] win;
        int          col, row;
    } vec_t;

    vec_t tab[4];

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        cyc();
    endtask

    initial begin
        tab[0] = '{24'h030201, 24'h060504, 24'h090807, 72'h090807_060504_030201, 0, 0};
        tab[1] = '{24'hA1B2C3, 24'h445566, 24'h0F0E0D, 72'h0F0E0D_445566_A1B2C3, 1, 0};
        tab[2] = '{24'hFFFFFF, 24'h000000, 24'h123456, 72'h123456_000000_FFFFFF, 0, 1};
        tab[3] = '{24'h800001, 24'h7F7F7F, 24'hDEADBE, 72'hDEADBE_7F7F7F_800001, 1, 1};

        reset = 1; start_a = 0; start_b = 0; ready_a = 0; ready_b = 0;
        d0 = '0; d1 = '0; d2 = '0; c0 = 0; c1 = 0; c2 = 0;
        repeat (2) cyc();
        reset = 0;
        cyc();

        // Basic 2x2 frame with data mapping, back-to-back at full rate.
        c0 = 6; c1 = 6; c2 = 6; ready_a = 1; start_a = 1;
        cyc();
        start_a = 0;
        for (int i = 0; i < 4; i++) begin
            d0 = tab[i].r0; d1 = tab[i].r1; d2 = tab[i].r2;
            @(negedge clk);
            chk("basic_pop", pop_a, 1);
            if (i > 0) begin
                chk("basic_data", data_a, tab[i-1].win);
                chk("basic_col", col_a, tab[i-1].col);
                chk("basic_row", row_a, tab[i-1].row);
            end
            cyc();
        end
        @(negedge clk);
        chk("basic_data_last", data_a, tab[3].win);
        chk("basic_col_last", col_a, tab[3].col);
        chk("basic_row_last", row_a, tab[3].row);
        chk("basic_no_pop_after_last", pop_a, 0);
        cyc();
        start_a = 1;                       // start during DONE is ignored
        @(negedge clk);
        chk("basic_done", done_a, 1);
        cyc();
        start_a = 0;
        @(negedge clk);
        chk("basic_done_pulse", done_a, 0);
        chk("start_in_done_ignored", busy_a, 0);
        cyc();

        // Backpressure: ready low for 5 cycles after the first window.
        ready_a = 0; d0 = 24'h111111; d1 = 24'h222222; d2 = 24'h333333; start_a = 1;
        cyc();
        start_a = 0;
        @(negedge clk);
        chk("bp_first_pop", pop_a, 1);
        cyc();
        d0 = 24'hAAAAAA; d1 = 24'hBBBBBB; d2 = 24'hCCCCCC;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_pop_held", pop_a, 0);
            chk("bp_data_stable", data_a, 72'h333333_222222_111111);
            chk("bp_col_stable", col_a, 0);
            cyc();
        end
        ready_a = 1;
        @(negedge clk);
        chk("bp_resume_pop", pop_a, 1);
        cyc();
        wait_done(20);
        cyc();

        // Starvation: one row below a full group.
        c0 = 9; c1 = 2; c2 = 9; start_a = 1;
        cyc();
        start_a = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("starve_pop", pop_a, 0);
            chk("starve_valid", valid_a, 0);
            cyc();
        end
        c1 = 3;
        @(negedge clk);
        chk("starve_release_pop", pop_a, 1);
        cyc();
        c1 = 9;
        wait_done(20);
        cyc();

        // Randomized 10x10 frame: random occupancy, data, ready and stray starts.
        sel = 1;
        cyc();
        start_b = 1;
        cyc();
        begin
            bit seen = 0;
            for (int k = 0; k < 3000; k++) begin
                c0 = 4'($urandom_range(0, 11));
                c1 = 4'($urandom_range(0, 11));
                c2 = 4'($urandom_range(0, 11));
                d0 = 24'($urandom); d1 = 24'($urandom); d2 = 24'($urandom);
                ready_b = ($urandom_range(0, 3) != 0);
                start_b = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                if (done_b) begin
                    seen = 1;
                    break;
                end
                cyc();
            end
            chk("rand_done_seen", seen, 1);
            chk("rand_accepted", m_accepted, W_B * R_B);
        end
        cyc();
        start_b = 0; c0 = 11; c1 = 11; c2 = 11; ready_b = 1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_pop", pop_b, 0);
            cyc();
        end

        // Reset mid-frame after three windows, then restart from (0,0).
        start_b = 1;
        cyc();
        start_b = 0;
        repeat (3) cyc();
        #1 reset = 1;
        #1;
        chk("abort_valid", valid_b, 0);
        chk("abort_busy", busy_b, 0);
        chk("abort_pop", pop_b, 0);
        chk("abort_data", data_b, 0);
        cyc();
        reset = 0;
        cyc();
        start_b = 1;
        cyc();
        start_b = 0;
        @(negedge clk);
        chk("restart_pop", pop_b, 1);
        cyc();
        @(negedge clk);
        chk("restart_valid", valid_b, 1);
        chk("restart_col", col_b, 0);
        chk("restart_row", row_b, 0);
        cyc();
        wait_done(300);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
